// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed seven-segment scan driver with double-buffered value
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic                  A,
    output logic                  B,
    output logic                  C,
    output logic                  D,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] EN_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] disp;
    logic [4*DIGITS-1:0] shadow;
    logic                wrap_q;

    logic                presc_last;
    logic                frame_edge;
    logic [3:0]          active_nib;
    logic                upper_zero;
    logic                blank;

    assign presc_last = (presc == PRESC_LAST);
    assign frame_edge = presc_last && (idx == IDX_LAST);

    // Select the active digit's nibble and decide whether it is a leading zero
    always_comb begin
        active_nib = disp[4*int'(idx) +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(idx)) && (disp[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        blank = blank_lz && (idx != '0) && upper_zero;
    end

    // Scan counters, shadow/commit buffering and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            disp       <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            wrap_q     <= 1'b0;
            A          <= 1'b0;
            B          <= 1'b0;
            C          <= 1'b0;
            D          <= 1'b0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            // dwell counter and digit index
            if (presc_last) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            // the old shadow commits before a same-cycle load replaces it
            if (frame_edge && pending) begin
                disp <= shadow;
            end
            if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end else if (frame_edge) begin
                pending <= 1'b0;
            end

            // outputs reflect the pre-edge scan position
            {A, B, C, D} <= active_nib;
            digit_en     <= blank ? '0 : (EN_ONE << idx);

            // delay one cycle so the pulse lines up with the new frame's digit 0
            wrap_q     <= frame_edge;
            frame_done <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    localparam int DIG = 4;
    localparam int PS  = 4;
    localparam int FR  = DIG * PS;

    logic            clk;
    logic            rst;
    logic            load;
    logic [15:0]     value;
    logic            blank_lz;
    logic            A, B, C, D;
    logic [DIG-1:0]  digit_en;
    logic            pending;
    logic            frame_done;

    int checks;
    int errors;

    // reference model: scan position derived from edges since reset release
    int          k;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;
    logic        m_pend;
    int          last_idx;
    logic [3:0]  e_nib;
    logic [3:0]  e_en;
    logic        e_pend;
    logic        e_fd;

    typedef struct {
        logic        r;
        logic        l;
        logic [15:0] v;
        logic [3:0]  nib;
        logic [3:0]  en;
        logic        pend;
        logic        fd;
    } vec_t;

    vec_t tbl[21];

    seg_scan_driver #(.DIGITS(DIG), .PRESCALE(PS)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .digit_en   (digit_en),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic l, input logic [15:0] v, input logic b);
        int  pos;
        logic [15:0] upper;
        if (r) begin
            k = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
            e_nib = '0; e_en = '0; e_pend = 1'b0; e_fd = 1'b0;
            last_idx = -1;
        end else begin
            pos      = k % FR;
            last_idx = pos / PS;
            upper    = m_disp >> (4 * last_idx);
            e_nib    = upper[3:0];
            e_en     = (b && last_idx > 0 && upper == 16'h0) ? 4'b0000 : 4'(1 << last_idx);
            e_fd     = (k > 0) && (pos == 0);
            if (pos == FR - 1 && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            if (l) begin
                m_shadow = v;
                m_pend   = 1'b1;
            end
            e_pend = m_pend;
            k++;
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [15:0] v, input logic b);
        rst = r; load = l; value = v; blank_lz = b;
        @(posedge clk);
        model(r, l, v, b);
        #1;
        chk("nibble", int'({A, B, C, D}), int'(e_nib));
        chk("digit_en", int'(digit_en), int'(e_en));
        chk("pending", int'(pending), int'(e_pend));
        chk("frame_done", int'(frame_done), int'(e_fd));
    endtask

    task automatic idle(input int n, input logic b);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, b);
    endtask

    // advance so that the next step's pre-edge position is pos
    task automatic align(input int pos, input logic b);
        for (int i = 0; i < FR && (k % FR) != pos; i++) step(1'b0, 1'b0, 16'h0, b);
        chk("align", k % FR, pos);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;
        checks = 0; errors = 0;
        k = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0; last_idx = -1;

        // reset for 3 cycles, then load 0x1234 one cycle after release
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b0, 16'h0, 4'h0, 4'b0000, 1'b0, 1'b0};
        for (int j = 0; j < 18; j++) begin
            tbl[3+j].r    = 1'b0;
            tbl[3+j].l    = (j == 1);
            tbl[3+j].v    = 16'h1234;
            tbl[3+j].nib  = (j >= 16) ? 4'h4 : 4'h0;
            tbl[3+j].en   = 4'(1 << ((j / PS) % DIG));
            tbl[3+j].pend = (j >= 1) && (j < 15);
            tbl[3+j].fd   = (j == 16);
        end
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].r, tbl[i].l, tbl[i].v, 1'b0);
            chk("tbl_nib", int'({A, B, C, D}), int'(tbl[i].nib));
            chk("tbl_en", int'(digit_en), int'(tbl[i].en));
            chk("tbl_pend", int'(pending), int'(tbl[i].pend));
            chk("tbl_fd", int'(frame_done), int'(tbl[i].fd));
        end
        // remainder of the 0x1234 frame: digits 1..3 show 3, 2, 1
        align(4, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            chk("d1234", int'({A, B, C, D}), 4 - last_idx);
        end

        // double load within one frame: only 0x00F0 is displayed
        align(0, 1'b0);
        step(1'b0, 1'b1, 16'hAAAA, 1'b0);
        step(1'b0, 1'b1, 16'h00F0, 1'b0);
        align(0, 1'b0);
        for (int i = 0; i < FR; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            chk("dbl_load", int'({A, B, C, D}), (last_idx == 1) ? 15 : 0);
        end

        // load coinciding with the frame edge
        step(1'b0, 1'b1, 16'h5555, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        align(FR - 1, 1'b0);
        step(1'b0, 1'b1, 16'h9999, 1'b0);
        chk("edge_pend", int'(pending), 1);
        for (int i = 0; i < FR; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            chk("edge_5s", int'({A, B, C, D}), 5);
        end
        for (int i = 0; i < FR; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            chk("edge_9s", int'({A, B, C, D}), 9);
        end
        chk("edge_pend_clr", int'(pending), 0);

        // leading-zero blanking of 0x0070 and 0x0000
        step(1'b0, 1'b1, 16'h0070, 1'b1);
        align(0, 1'b1);
        for (int i = 0; i < FR; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1);
            chk("blank70_en", int'(digit_en), (last_idx >= 2) ? 0 : (1 << last_idx));
            chk("blank70_nib", int'({A, B, C, D}), (last_idx == 1) ? 7 : 0);
        end
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        align(0, 1'b1);
        for (int i = 0; i < FR; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1);
            chk("blank0_en", int'(digit_en), (last_idx == 0) ? 1 : 0);
        end

        // reset during digit 2 with a value pending
        step(1'b0, 1'b1, 16'h7777, 1'b0);
        align(8, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h3333, 1'b0);
        chk("rst_en", int'(digit_en), 0);
        chk("rst_nib", int'({A, B, C, D}), 0);
        chk("rst_pend", int'(pending), 0);
        for (int i = 0; i < 2 * FR; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            chk("rst_disp0", int'({A, B, C, D}), 0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                 16'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
